// File: rtl/gray_fifo_pkg.sv
// Shared types and Gray-code helpers for the asynchronous FIFO pointer engines.
// Helpers take an explicit width so one definition serves every pointer size.
package gray_fifo_pkg;

    typedef enum logic {
        RD_SIDE = 1'b0,
        WR_SIDE = 1'b1
    } ptr_mode_e;

    localparam int MAX_W = 32;

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b, input int w);
        logic [MAX_W-1:0] bm;
        bm = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                bm[i] = b[i];
            end
        end
        return bm ^ (bm >> 1);
    endfunction

    // Binary bit i is the XOR of all Gray bits at or above i.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g, input int w);
        logic [MAX_W-1:0] b;
        logic             acc;
        b   = '0;
        acc = 1'b0;
        for (int i = MAX_W - 1; i >= 0; i--) begin
            if (i < w) begin
                acc  = acc ^ g[i];
                b[i] = acc;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_fifo_ptr_sync.sv
// Multi-bit flop chain carrying the remote Gray pointer into the local clock domain.
// Kept as its own module so CDC constraints can target it by name.
module gray_sync #(
    parameter int W      = 5,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage_reg [STAGES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_reg[0] <= '0;
        end else begin
            stage_reg[0] <= d;
        end
    end

    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    stage_reg[gi] <= '0;
                end else begin
                    stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/gray_fifo_ptr.sv
// One side of an asynchronous FIFO: local binary/Gray pointer, synchronised remote
// pointer, and registered full/empty, almost and fill-level status.
module gray_fifo_ptr
    import gray_fifo_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int MODE        = 1,
    parameter int SYNC_STAGES = 2,
    parameter int ALMOST_TH   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_en,
    output logic              inc_ack,
    input  logic [ADDR_W:0]   remote_gray_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic [ADDR_W:0]   gray_ptr_out,
    output logic [ADDR_W:0]   remote_bin_out,
    output logic [ADDR_W:0]   level_out,
    output logic              flag_out,
    output logic              almost_out
);

    localparam int        PTR_W    = ADDR_W + 1;
    localparam int        DEPTH    = 2 ** ADDR_W;
    localparam ptr_mode_e SIDE     = (MODE != 0) ? WR_SIDE : RD_SIDE;
    localparam logic      RST_FLAG = (SIDE == RD_SIDE);

    logic [PTR_W-1:0] ptr_bin_reg;
    logic [PTR_W-1:0] gray_reg;
    logic [PTR_W-1:0] remote_bin_reg;
    logic [PTR_W-1:0] level_reg;
    logic             flag_reg;
    logic             almost_reg;

    logic [PTR_W-1:0] bin_next;
    logic [PTR_W-1:0] gray_next;
    logic [PTR_W-1:0] rsync_gray;
    logic [PTR_W-1:0] rsync_bin;
    logic [PTR_W-1:0] level_next;
    logic             flag_next;
    logic             almost_next;

    gray_sync #(
        .W      (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (remote_gray_in),
        .q     (rsync_gray)
    );

    assign inc_ack   = inc_en & ~flag_reg;
    assign bin_next  = ptr_bin_reg + PTR_W'(inc_ack);
    assign gray_next = PTR_W'(bin2gray(MAX_W'(bin_next), PTR_W));
    assign rsync_bin = PTR_W'(gray2bin(MAX_W'(rsync_gray), PTR_W));

    // Status is computed from bin_next so an accepted increment is reflected at its own edge.
    always_comb begin
        level_next  = '0;
        flag_next   = RST_FLAG;
        almost_next = RST_FLAG;
        if (SIDE == WR_SIDE) begin
            level_next  = bin_next - rsync_bin;
            flag_next   = (level_next == PTR_W'(DEPTH));
            almost_next = (level_next >= PTR_W'(DEPTH - ALMOST_TH));
        end else begin
            level_next  = rsync_bin - bin_next;
            flag_next   = (level_next == '0);
            almost_next = (level_next <= PTR_W'(ALMOST_TH));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_bin_reg    <= '0;
            gray_reg       <= '0;
            remote_bin_reg <= '0;
            level_reg      <= '0;
            flag_reg       <= RST_FLAG;
            almost_reg     <= RST_FLAG;
        end else begin
            ptr_bin_reg    <= bin_next;
            gray_reg       <= gray_next;
            remote_bin_reg <= rsync_bin;
            level_reg      <= level_next;
            flag_reg       <= flag_next;
            almost_reg     <= almost_next;
        end
    end

    assign addr_out       = ptr_bin_reg[ADDR_W-1:0];
    assign gray_ptr_out   = gray_reg;
    assign remote_bin_out = remote_bin_reg;
    assign level_out      = level_reg;
    assign flag_out       = flag_reg;
    assign almost_out     = almost_reg;

endmodule

// File: tb/tb_gray_fifo_ptr.sv
// Directed bench: a write-side and a read-side pointer engine, driven standalone or
// cross-connected as the two halves of a FIFO.
module tb_gray_fifo_ptr;

    logic       clk = 1'b0;
    logic       wr_rst_n, rd_rst_n;
    logic       wr_inc, rd_inc;
    logic       wr_ack, rd_ack;
    logic       pair;
    logic [4:0] wr_remote_drv, rd_remote_drv;
    logic [4:0] wr_remote, rd_remote;
    logic [3:0] wr_addr, rd_addr;
    logic [4:0] wr_gray, rd_gray, wr_rbin, rd_rbin, wr_level, rd_level;
    logic       wr_flag, rd_flag, wr_almost, rd_almost;

    int nvec  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    assign wr_remote = pair ? rd_gray : wr_remote_drv;
    assign rd_remote = pair ? wr_gray : rd_remote_drv;

    gray_fifo_ptr #(.ADDR_W(4), .MODE(1), .SYNC_STAGES(2), .ALMOST_TH(2)) dut_wr (
        .clk            (clk),
        .rst_n          (wr_rst_n),
        .inc_en         (wr_inc),
        .inc_ack        (wr_ack),
        .remote_gray_in (wr_remote),
        .addr_out       (wr_addr),
        .gray_ptr_out   (wr_gray),
        .remote_bin_out (wr_rbin),
        .level_out      (wr_level),
        .flag_out       (wr_flag),
        .almost_out     (wr_almost)
    );

    gray_fifo_ptr #(.ADDR_W(4), .MODE(0), .SYNC_STAGES(2), .ALMOST_TH(2)) dut_rd (
        .clk            (clk),
        .rst_n          (rd_rst_n),
        .inc_en         (rd_inc),
        .inc_ack        (rd_ack),
        .remote_gray_in (rd_remote),
        .addr_out       (rd_addr),
        .gray_ptr_out   (rd_gray),
        .remote_bin_out (rd_rbin),
        .level_out      (rd_level),
        .flag_out       (rd_flag),
        .almost_out     (rd_almost)
    );

    function automatic int gr(input int i);
        return (i ^ (i >> 1)) & 31;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int gtab [8] = '{1, 3, 2, 6, 7, 5, 4, 12};
    int wc, rc, occ, wa, ra;
    logic [4:0] prev_gray;

    initial begin
        wr_rst_n = 1'b0; rd_rst_n = 1'b0;
        wr_inc = 1'b0; rd_inc = 1'b0; pair = 1'b0;
        wr_remote_drv = '0; rd_remote_drv = '0;
        step(); step();
        chk("rst_wr_level", wr_level, 0);
        chk("rst_wr_flag", wr_flag, 0);
        chk("rst_wr_almost", wr_almost, 0);
        chk("rst_wr_gray", wr_gray, 0);
        chk("rst_rd_flag", rd_flag, 1);
        chk("rst_rd_almost", rd_almost, 1);
        chk("rst_rd_level", rd_level, 0);
        wr_rst_n = 1'b1; rd_rst_n = 1'b1;
        step();

        // Fill the write side against a remote pointer held at zero.
        prev_gray = wr_gray;
        for (int i = 1; i <= 16; i++) begin
            wr_inc = 1'b1;
            #1;
            chk("fill_ack", wr_ack, 1);
            step();
            chk("fill_level", wr_level, i);
            chk("fill_flag", wr_flag, (i == 16));
            chk("fill_almost", wr_almost, (i >= 14));
            chk("fill_addr", wr_addr, i % 16);
            chk("fill_gray", wr_gray, gr(i));
            chk("gray_onebit", $countones(prev_gray ^ wr_gray), 1);
            if (i <= 8) chk("gray_table", wr_gray, gtab[i-1]);
            $display("wr inc %0d: level=%0d gray=%0d flag=%0d", i, wr_level, wr_gray, wr_flag);
            prev_gray = wr_gray;
        end
        #1;
        chk("full_ack", wr_ack, 0);
        step();
        chk("full_level", wr_level, 16);
        chk("full_gray", wr_gray, gr(16));
        chk("full_addr", wr_addr, 0);
        chk("full_flag", wr_flag, 1);
        wr_inc = 1'b0;

        // Reset in the middle of operation, with the increment strobe asserted.
        wr_rst_n = 1'b0; step(); wr_rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr_inc = 1'b1; step();
        end
        chk("pre_rst_level", wr_level, 10);
        wr_rst_n = 1'b0; wr_inc = 1'b1; step();
        chk("midrst_level", wr_level, 0);
        chk("midrst_gray", wr_gray, 0);
        chk("midrst_addr", wr_addr, 0);
        chk("midrst_flag", wr_flag, 0);
        chk("midrst_almost", wr_almost, 0);
        chk("midrst_rbin", wr_rbin, 0);
        wr_rst_n = 1'b1; wr_inc = 1'b0; step();
        chk("post_rst_gray", wr_gray, 0);
        $display("wr reset: level=%0d gray=%0d", wr_level, wr_gray);

        // Read side: remote Gray 2 (binary 3) takes SYNC_STAGES edges to show.
        rd_inc = 1'b1;
        #1;
        chk("empty_ack", rd_ack, 0);
        rd_inc = 1'b0;
        rd_remote_drv = 5'd2;
        step();
        chk("sync_k_level", rd_level, 0);
        step();
        chk("sync_k1_level", rd_level, 0);
        chk("sync_k1_flag", rd_flag, 1);
        step();
        chk("sync_k2_level", rd_level, 3);
        chk("sync_k2_flag", rd_flag, 0);
        chk("sync_k2_almost", rd_almost, 0);
        chk("sync_k2_rbin", rd_rbin, 3);
        for (int j = 1; j <= 3; j++) begin
            rd_inc = 1'b1;
            #1;
            chk("read_ack", rd_ack, 1);
            step();
            chk("read_level", rd_level, 3 - j);
            chk("read_flag", rd_flag, (j == 3));
            chk("read_almost", rd_almost, 1);
            chk("read_addr", rd_addr, j);
            $display("rd read %0d: level=%0d flag=%0d", j, rd_level, rd_flag);
        end
        #1;
        chk("underflow_ack", rd_ack, 0);
        step();
        chk("underflow_addr", rd_addr, 3);
        rd_inc = 1'b0;

        // Remote advance and local read folded into the same level update.
        rd_remote_drv = 5'd6;
        for (int j = 0; j < 3; j++) begin
            step();
            chk("inv_empty", (rd_level != 0) || rd_flag, 1);
        end
        chk("r4_level", rd_level, 1);
        rd_remote_drv = 5'd5;
        step(); step();
        chk("r6_pre_level", rd_level, 1);
        rd_inc = 1'b1;
        #1;
        chk("fold_ack", rd_ack, 1);
        step();
        chk("fold_level", rd_level, 2);
        chk("fold_flag", rd_flag, 0);
        chk("fold_addr", rd_addr, 4);
        $display("rd fold: level=%0d addr=%0d", rd_level, rd_addr);
        for (int j = 0; j < 2; j++) begin
            step();
            chk("inv_empty", (rd_level != 0) || rd_flag, 1);
        end
        chk("drain_level", rd_level, 0);
        chk("drain_flag", rd_flag, 1);
        rd_inc = 1'b0;
        rd_remote_drv = 5'd4;
        for (int j = 0; j < 3; j++) begin
            step();
            chk("inv_empty", (rd_level != 0) || rd_flag, 1);
        end
        chk("r7_level", rd_level, 1);
        chk("r7_rbin", rd_rbin, 7);

        // Cross-connected pair: long run through pointer wrap.
        pair = 1'b1;
        wr_rst_n = 1'b0; rd_rst_n = 1'b0; wr_inc = 1'b0; rd_inc = 1'b0;
        step(); step();
        wr_rst_n = 1'b1; rd_rst_n = 1'b1;
        wc = 0; rc = 0;
        for (int c = 0; c < 120; c++) begin
            wr_inc = (c % 3) != 2;
            rd_inc = (c % 4) != 0;
            #1;
            wa = int'(wr_ack);
            ra = int'(rd_ack);
            step();
            wc += wa;
            rc += ra;
            occ = wc - rc;
            chk("pair_occ", (occ >= 0) && (occ <= 16), 1);
            chk("pair_wr_le16", wr_level <= 16, 1);
            chk("pair_rd_le16", rd_level <= 16, 1);
            chk("pair_wr_cons", int'(wr_level) >= occ, 1);
            chk("pair_rd_cons", int'(rd_level) <= occ, 1);
            chk("pair_no_false_notfull", (occ != 16) || wr_flag, 1);
            chk("pair_no_false_notempty", (occ != 0) || rd_flag, 1);
            chk("pair_wr_gray", wr_gray, gr(wc % 32));
            chk("pair_rd_addr", rd_addr, rc % 16);
        end
        wr_inc = 1'b0; rd_inc = 1'b0;
        $display("pair run: writes=%0d reads=%0d", wc, rc);
        chk("pair_reads_ge40", rc >= 40, 1);
        chk("pair_wrapped", wc > 32, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
